// File: rtl/cnt_bank_pkg.sv
// Shared constants, op-select encoding and helpers for the cnt_bank counter bank.
// Optional threshold compare is enabled with `define CNT_BANK_THRESH_EN.
package cnt_bank_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } op_e;

  // All-ones value for a w-bit channel. Callers truncate the result to their own width.
  function automatic logic [63:0] all_ones(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/cnt_bank_ch.sv
// One counter channel: priority decode, next-state, boundary/event flags.
// With CNT_BANK_THRESH_EN defined it adds a registered (next q >= thr) compare.
module cnt_bank_ch
  import cnt_bank_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               SAT_MODE = MODE_WRAP,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic             inc,
  input  logic             dec,
  input  logic             ovf_clr,
`ifdef CNT_BANK_THRESH_EN
  input  logic [WIDTH-1:0] thr,
  output logic             hit,
`endif
  output logic [WIDTH-1:0] q,
  output logic             at_zero,
  output logic             at_max,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(all_ones(WIDTH));
  localparam bit               SAT  = (SAT_MODE == MODE_SAT);

  op_e              op;
  logic [WIDTH-1:0] q_nxt;
  logic             evt;

  always_comb begin
    op = OP_HOLD;
    if (clr)              op = OP_CLR;
    else if (we)          op = OP_LOAD;
    else if (inc && !dec) op = OP_INC;
    else if (dec && !inc) op = OP_DEC;
  end

  always_comb begin
    q_nxt = q;
    evt   = 1'b0;
    case (op)
      OP_CLR:  q_nxt = RST_VAL;
      OP_LOAD: q_nxt = d;
      OP_INC: begin
        evt   = (q == MAXV);
        q_nxt = (evt && SAT) ? q : q + 1'b1;
      end
      OP_DEC: begin
        evt   = (q == '0);
        q_nxt = (evt && SAT) ? q : q - 1'b1;
      end
      default: ;
    endcase
  end

  // Hold is by omission: the register is only written for a real op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              q <= RST_VAL;
    else if (op != OP_HOLD)  q <= q_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= evt;
      if (evt)                 ovf <= 1'b1;
      else if (ovf_clr || clr) ovf <= 1'b0;
    end
  end

`ifdef CNT_BANK_THRESH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hit <= 1'b0;
    else        hit <= (q_nxt >= thr);
  end
`endif

  assign at_zero = (q == '0);
  assign at_max  = (q == MAXV);

endmodule

// File: rtl/cnt_bank.sv
// Bank of NCH independent wrap/saturate counters with load, clear and sticky overflow.
// Defining CNT_BANK_THRESH_EN adds ch_thr/ch_hit threshold ports.
module cnt_bank
  import cnt_bank_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               NCH      = 4,
  parameter int               SAT_MODE = MODE_WRAP,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       ch_clr,
  input  logic [NCH-1:0]       ch_we,
  input  logic [NCH*WIDTH-1:0] ch_d,
  input  logic [NCH-1:0]       ch_inc,
  input  logic [NCH-1:0]       ch_dec,
  input  logic [NCH-1:0]       ovf_clr,
`ifdef CNT_BANK_THRESH_EN
  input  logic [NCH*WIDTH-1:0] ch_thr,
  output logic [NCH-1:0]       ch_hit,
`endif
  output logic [NCH*WIDTH-1:0] ch_q,
  output logic [NCH-1:0]       ch_zero,
  output logic [NCH-1:0]       ch_max,
  output logic [NCH-1:0]       ch_wrap,
  output logic [NCH-1:0]       ch_ovf
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cnt_bank_ch #(
      .WIDTH    (WIDTH),
      .SAT_MODE (SAT_MODE),
      .RST_VAL  (RST_VAL)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .clr     (ch_clr[i]),
      .we      (ch_we[i]),
      .d       (ch_d[i*WIDTH +: WIDTH]),
      .inc     (ch_inc[i]),
      .dec     (ch_dec[i]),
      .ovf_clr (ovf_clr[i]),
`ifdef CNT_BANK_THRESH_EN
      .thr     (ch_thr[i*WIDTH +: WIDTH]),
      .hit     (ch_hit[i]),
`endif
      .q       (ch_q[i*WIDTH +: WIDTH]),
      .at_zero (ch_zero[i]),
      .at_max  (ch_max[i]),
      .wrap    (ch_wrap[i]),
      .ovf     (ch_ovf[i])
    );
  end

endmodule

// File: tb/tb_cnt_bank.sv
// Directed bench for cnt_bank: one wrap-mode bank (RST_VAL 0) and one saturate bank (RST_VAL 5).
module tb_cnt_bank;
  localparam int W = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   w_clr, w_we, w_inc, w_dec, w_oclr;
  logic [N*W-1:0] w_d, w_q;
  logic [N-1:0]   w_zero, w_max, w_wrap, w_ovf;
  logic [N-1:0]   s_clr, s_we, s_inc, s_dec, s_oclr;
  logic [N*W-1:0] s_d, s_q;
  logic [N-1:0]   s_zero, s_max, s_wrap, s_ovf;
`ifdef CNT_BANK_THRESH_EN
  logic [N*W-1:0] w_thr, s_thr;
  logic [N-1:0]   w_hit, s_hit;
`endif

  cnt_bank #(.WIDTH(W), .NCH(N), .SAT_MODE(0), .RST_VAL(4'd0)) dut_w (
    .clk(clk), .reset(reset), .ch_clr(w_clr), .ch_we(w_we), .ch_d(w_d),
    .ch_inc(w_inc), .ch_dec(w_dec), .ovf_clr(w_oclr),
`ifdef CNT_BANK_THRESH_EN
    .ch_thr(w_thr), .ch_hit(w_hit),
`endif
    .ch_q(w_q), .ch_zero(w_zero), .ch_max(w_max), .ch_wrap(w_wrap), .ch_ovf(w_ovf));

  cnt_bank #(.WIDTH(W), .NCH(N), .SAT_MODE(1), .RST_VAL(4'd5)) dut_s (
    .clk(clk), .reset(reset), .ch_clr(s_clr), .ch_we(s_we), .ch_d(s_d),
    .ch_inc(s_inc), .ch_dec(s_dec), .ovf_clr(s_oclr),
`ifdef CNT_BANK_THRESH_EN
    .ch_thr(s_thr), .ch_hit(s_hit),
`endif
    .ch_q(s_q), .ch_zero(s_zero), .ch_max(s_max), .ch_wrap(s_wrap), .ch_ovf(s_ovf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    w_clr = '0; w_we = '0; w_inc = '0; w_dec = '0; w_oclr = '0; w_d = '0;
    s_clr = '0; s_we = '0; s_inc = '0; s_dec = '0; s_oclr = '0; s_d = '0;
`ifdef CNT_BANK_THRESH_EN
    w_thr = {N{4'd5}};
    s_thr = {N{4'd15}};
`endif
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_q",    w_q,    16'h0000);
    chk("rst_w_zero", w_zero, 4'hF);
    chk("rst_w_max",  w_max,  4'h0);
    chk("rst_w_wrap", w_wrap, 4'h0);
    chk("rst_w_ovf",  w_ovf,  4'h0);
    chk("rst_s_q",    s_q,    16'h5555);
    chk("rst_s_zero", s_zero, 4'h0);
    reset = 1'b1;

    // wrap-mode full count on ch0
    w_inc[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = 4'(k);
      chk($sformatf("t1_q_%0d", k),    w_q[3:0],  e);
      chk($sformatf("t1_zero_%0d", k), w_zero[0], e == 4'd0);
      chk($sformatf("t1_max_%0d", k),  w_max[0],  e == 4'd15);
      chk($sformatf("t1_wrap_%0d", k), w_wrap[0], k == 16);
      chk($sformatf("t1_ovf_%0d", k),  w_ovf[0],  k == 16);
    end
    w_inc[0] = 1'b0;
    tick();
    chk("t1_hold_q",    w_q[3:0],  4'd0);
    chk("t1_hold_wrap", w_wrap[0], 1'b0);
    chk("t1_hold_ovf",  w_ovf[0],  1'b1);
    chk("t1_others",    w_q[15:4], 12'h000);

    // saturate on ch0
    s_we[0] = 1'b1; s_d[3:0] = 4'd14;
    tick();
    chk("t2_load", s_q[3:0], 4'd14);
    s_we[0] = 1'b0; s_inc[0] = 1'b1;
    tick(); chk("t2_q1", s_q[3:0], 4'd15); chk("t2_w1", s_wrap[0], 1'b0); chk("t2_max1", s_max[0], 1'b1);
    tick(); chk("t2_q2", s_q[3:0], 4'd15); chk("t2_w2", s_wrap[0], 1'b1);
    tick(); chk("t2_q3", s_q[3:0], 4'd15); chk("t2_w3", s_wrap[0], 1'b1); chk("t2_ovf", s_ovf[0], 1'b1);
    s_inc[0] = 1'b0; s_we[0] = 1'b1; s_d[3:0] = 4'd0;
    tick(); chk("t2_ld0", s_q[3:0], 4'd0); chk("t2_ld0_w", s_wrap[0], 1'b0); chk("t2_ld0_zero", s_zero[0], 1'b1);
    s_we[0] = 1'b0; s_dec[0] = 1'b1;
    tick(); chk("t2_dec_q", s_q[3:0], 4'd0); chk("t2_dec_w", s_wrap[0], 1'b1);
    s_dec[0] = 1'b0;

    // priority on ch1 (RST_VAL 5)
    s_we[1] = 1'b1; s_d[7:4] = 4'd2;
    tick(); chk("t3_pre", s_q[7:4], 4'd2);
    s_clr[1] = 1'b1; s_inc[1] = 1'b1; s_d[7:4] = 4'd9;
    tick(); chk("t3_clr", s_q[7:4], 4'd5); chk("t3_clr_w", s_wrap[1], 1'b0);
    s_clr[1] = 1'b0;
    tick(); chk("t3_we", s_q[7:4], 4'd9);
    s_we[1] = 1'b0; s_dec[1] = 1'b1;
    tick(); chk("t3_both", s_q[7:4], 4'd9); chk("t3_both_w", s_wrap[1], 1'b0);
    s_inc[1] = 1'b0; s_dec[1] = 1'b0;

    // sticky overflow on ch2
    s_we[2] = 1'b1; s_d[11:8] = 4'd15;
    tick(); s_we[2] = 1'b0; s_inc[2] = 1'b1;
    tick(); chk("t4_evt_w", s_wrap[2], 1'b1); chk("t4_evt_o", s_ovf[2], 1'b1);
    s_inc[2] = 1'b0; s_oclr[2] = 1'b1;
    tick(); chk("t4_clr_o", s_ovf[2], 1'b0); chk("t4_clr_w", s_wrap[2], 1'b0); chk("t4_clr_q", s_q[11:8], 4'd15);
    s_inc[2] = 1'b1;
    tick(); chk("t4_both_o", s_ovf[2], 1'b1); chk("t4_both_w", s_wrap[2], 1'b1);
    s_inc[2] = 1'b0; s_oclr[2] = 1'b0;
    tick(); chk("t4_keep_o", s_ovf[2], 1'b1); chk("t4_keep_w", s_wrap[2], 1'b0);
    s_clr[2] = 1'b1;
    tick(); chk("t4_chclr_o", s_ovf[2], 1'b0); chk("t4_chclr_q", s_q[11:8], 4'd5);
    s_clr[2] = 1'b0;

    // async reset mid-count on wrap ch1
    w_we[1] = 1'b1; w_d[7:4] = 4'd6;
    tick(); w_we[1] = 1'b0; w_inc[1] = 1'b1;
    tick(); chk("t5_pre", w_q[7:4], 4'd7);
    #3 reset = 1'b0;
    #1;
    chk("t5_q",    w_q,    16'h0000);
    chk("t5_ovf",  w_ovf,  4'h0);
    chk("t5_wrap", w_wrap, 4'h0);
    chk("t5_s_q",  s_q,    16'h5555);
    #1 reset = 1'b1;
    tick(); chk("t5_after", w_q[7:4], 4'd1); chk("t5_ch0", w_q[3:0], 4'd0);
    w_inc[1] = 1'b0;

`ifdef CNT_BANK_THRESH_EN
    chk("t6_rst_hit", w_hit[3], 1'b0);
    w_we[3] = 1'b1; w_d[15:12] = 4'd3;
    tick(); chk("t6_q3", w_q[15:12], 4'd3); chk("t6_h3", w_hit[3], 1'b0);
    w_we[3] = 1'b0; w_inc[3] = 1'b1;
    for (int v = 4; v <= 7; v++) begin
      tick();
      chk($sformatf("t6_q%0d", v), w_q[15:12], 4'(v));
      chk($sformatf("t6_h%0d", v), w_hit[3],   v >= 5);
    end
    w_inc[3] = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnt_bank.md
Name: cnt_bank

Overview:
Parametrised bank of NCH independent enabled registers/counters, each WIDTH bits. It is the next generation of the team's single-bit enabled D flip-flop.
- Per channel: clear, load (write-enable), increment and decrement.
- Selectable wrap or saturate mode, boundary flags, wrap pulse and sticky overflow.
- Used as the generic event/occupancy counter primitive in datapath and control blocks.
- Register holds by omission of assignment: no explicit q<=q path, so synthesis maps hold to the enable.

Parameters:
- WIDTH, 8, bits per channel (>=2).
- NCH, 4, number of channels (>=1).
- SAT_MODE, 0, 0 = wrap modulo 2^WIDTH; 1 = saturate at 0 and 2^WIDTH-1.
- RST_VAL, 0, reset/clear value of every channel (WIDTH bits, must be < 2^WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ch_clr  in  NCH  per-channel synchronous clear to RST_VAL.
- ch_we  in  NCH  per-channel load enable.
- ch_d  in  NCH*WIDTH  load data; channel i at [i*WIDTH +: WIDTH].
- ch_inc  in  NCH  per-channel increment by 1.
- ch_dec  in  NCH  per-channel decrement by 1.
- ovf_clr  in  NCH  per-channel sticky-flag clear.
- ch_q  out  NCH*WIDTH  registered channel values.
- ch_zero  out  NCH  q == 0, decoded from the register.
- ch_max  out  NCH  q == 2^WIDTH-1, decoded from the register.
- ch_wrap  out  NCH  registered one-cycle pulse on wrap or saturation event.
- ch_ovf  out  NCH  sticky: set on any wrap/saturation event.

Behaviour:
- Reset (reset=0, asynchronous): ch_q = RST_VAL for all channels, ch_wrap = 0, ch_ovf = 0. ch_zero and ch_max follow from ch_q.
- Per-channel priority, evaluated on each rising edge: ch_clr > ch_we > (ch_inc XOR ch_dec) > hold.
  - clr: q <= RST_VAL; no wrap event.
  - we: q <= d; no wrap event.
  - inc only: q <= q+1. At q = max: in wrap mode q <= 0; in saturate mode q stays at max. Either case is an event.
  - dec only: q <= q-1. At q = 0: in wrap mode q <= max; in saturate mode q stays at 0. Either case is an event.
  - inc and dec together: hold, no event.
  - None active: hold. The register is not written, so its enable is deasserted.
- Event: ch_wrap[i] <= 1 for exactly the cycle in which the new q is visible; otherwise ch_wrap[i] <= 0.
- Sticky flag: ch_ovf[i] <= 1 on an event. Otherwise it is cleared by ovf_clr[i] or ch_clr[i]. If an event and a clear occur in the same cycle, set wins.
- Arithmetic: unsigned, WIDTH bits. No carry is kept beyond the event flag.
- Latency: one cycle from control input to ch_q, ch_wrap and ch_ovf. Flag outputs add no further delay.
- Channels are fully independent. There is no cross-channel interaction.
- Reset asserted mid-operation forces reset values immediately. The first edge after deassertion acts on the inputs present at that edge.

Optional Feature:
- Macro: CNT_BANK_THRESH_EN.
- Defined: adds input ch_thr (NCH*WIDTH) and output ch_hit (NCH).
  - ch_hit[i] is registered and equals (next q >= thr) after each edge, so it is cycle-aligned with ch_q.
  - ch_hit resets to 0.
  - ch_thr is sampled every cycle; a change takes effect on the next edge.
- Undefined: ch_thr and ch_hit ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package cnt_bank_pkg holds:
  - mode constants MODE_WRAP = 0 and MODE_SAT = 1;
  - a localparam function computing all-ones for a given WIDTH;
  - an op-select typedef: OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC.
- Sub-module cnt_bank_ch implements one channel (priority decode, next-state, flags and optional threshold). Its parameters are WIDTH, SAT_MODE and RST_VAL.
- The top level instantiates cnt_bank_ch NCH times in a generate loop and slices the flat buses.

Test Plan:
1. WIDTH=4, SAT_MODE=0: reset, then 16 x inc on ch0 -> q 0..15 then 0. ch_wrap pulses once on the edge returning to 0; ch_ovf stays 1; ch_zero and ch_max are correct at each value.
2. WIDTH=4, SAT_MODE=1: load 14, then 3 x inc -> q 15, 15, 15 with ch_wrap on the 2nd and 3rd incs. Then dec from 0 -> q stays 0 and ch_wrap=1.
3. Priority on ch1: clr=we=inc=1 with d=9 -> q=RST_VAL. Then we=inc=1 with d=9 -> q=9. Then inc=dec=1 -> q stays 9, ch_wrap=0.
4. Sticky: force wrap on ch2, then assert ovf_clr alone -> ch_ovf falls the next cycle. Then assert ovf_clr in the same cycle as a wrap event -> ch_ovf stays 1.
5. Assert reset asynchronously between edges during a count of 7 -> ch_q=RST_VAL and ch_wrap/ch_ovf=0 immediately. Release, then inc -> q=RST_VAL+1.
6. CNT_BANK_THRESH_EN defined, thr=5: count 3..7 -> ch_hit=0,0,1,1,1 aligned with q 3..7. Rebuild without the macro and confirm ports are absent and tests 1-5 still pass.
